p0010_sieve_param: RTL and testbench

P0010_SIEVE_PARAM -- requirements
Module: p0010_sieve_param

---
 rtl/p0010_sieve_param.sv | 214 +++++++++++++++++++++
 tb/tb_p0010_sieve_param.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p0010_sieve_param.sv
// Sieve of Eratosthenes engine: sums and counts every prime <= limit using an
// internal one-bit-per-entry array. Optional prime stream: P0010_SIEVE_STREAM_EN.
module p0010_sieve_param #(
    parameter int unsigned LIMIT_MAX = 2_000_000,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RESULT_W  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   limit,
`ifdef P0010_SIEVE_STREAM_EN
    output logic                prime_valid,
    output logic [ADDR_W-1:0]   prime_data,
    input  logic                prime_ready,
`endif
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [RESULT_W-1:0] result,
    output logic [ADDR_W-1:0]   count
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold the last run
    // INIT  | set sieve entries 0..N to 1, one per cycle
    // SCAN  | test entry[idx]; accumulate primes
    // MARK  | clear multiples of idx starting at idx*idx
    // FIN   | raise done, drop busy

    localparam int unsigned MUL_W    = 2 * ADDR_W;
    localparam int unsigned SIEVE_AW = (LIMIT_MAX < 1) ? 1 : $clog2(LIMIT_MAX + 1);
    localparam int unsigned SUM_W    = ((RESULT_W > ADDR_W) ? RESULT_W : ADDR_W) + 1;
    localparam logic [MUL_W-1:0] LIMIT_MAX_X = MUL_W'(LIMIT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SCAN,
        MARK,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     n_q, n_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [MUL_W-1:0]      mul_q, mul_d;
    logic [RESULT_W-1:0]   result_q, result_d;
    logic [ADDR_W-1:0]     count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  sieve [0:LIMIT_MAX];
    logic                  wr_en;
    logic [SIEVE_AW-1:0]   wr_addr;
    logic                  wr_data;

    logic [MUL_W-1:0]      idx_x;
    logic [MUL_W-1:0]      n_x;
    logic [MUL_W-1:0]      sq;
    logic [SUM_W-1:0]      sum_ext;
    logic                  entry;
    logic                  in_range;
    logic                  prime_hit;
    logic                  accept;

    // Products are formed at double width so idx*idx or mul+idx never wraps below N.
    assign idx_x    = MUL_W'(idx_q);
    assign n_x      = MUL_W'(n_q);
    assign sq       = idx_x * idx_x;
    assign sum_ext  = SUM_W'(result_q) + SUM_W'(idx_q);
    assign in_range = (idx_x <= n_x);
    assign entry    = in_range && sieve[idx_q[SIEVE_AW-1:0]];
    assign prime_hit = (state_q == SCAN) && entry;

`ifdef P0010_SIEVE_STREAM_EN
    assign prime_valid = prime_hit;
    assign prime_data  = idx_q;
    assign accept      = prime_ready;
`else
    assign accept      = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            idx_q    <= '0;
            mul_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            mul_q    <= mul_d;
            result_q <= result_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Sieve storage is deliberately not reset; INIT rewrites every entry a run uses.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sieve[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        mul_d    = mul_q;
        result_d = result_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d      = limit;
                    idx_d    = '0;
                    mul_d    = '0;
                    result_d = '0;
                    count_d  = '0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (MUL_W'(limit) > LIMIT_MAX_X) begin
                        error_d = 1'b1;
                        state_d = FIN;
                    end else if (limit < ADDR_W'(2)) begin
                        state_d = FIN;
                    end else begin
                        state_d = INIT;
                    end
                end
            end

            INIT: begin
                wr_en   = 1'b1;
                wr_addr = idx_q[SIEVE_AW-1:0];
                wr_data = 1'b1;
                if (idx_q == n_q) begin
                    idx_d   = ADDR_W'(2);
                    state_d = SCAN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            SCAN: begin
                if (!in_range) begin
                    state_d = FIN;
                end else if (!prime_hit) begin
                    idx_d = idx_q + 1'b1;
                end else if (accept) begin
                    result_d = sum_ext[RESULT_W-1:0];
                    if (|sum_ext[SUM_W-1:RESULT_W]) begin
                        error_d = 1'b1;
                    end
                    count_d = count_q + 1'b1;
                    if (sq <= n_x) begin
                        mul_d   = sq;
                        state_d = MARK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            MARK: begin
                if (mul_q > n_x) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SCAN;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = mul_q[SIEVE_AW-1:0];
                    wr_data = 1'b0;
                    mul_d   = mul_q + idx_x;
                end
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;
    assign count  = count_q;

endmodule

// File: tb/tb_p0010_sieve_param.sv
// Bench for p0010_sieve_param: trial-division reference model, a main instance
// and a narrow-accumulator instance for wrap/error behaviour.
module tb_p0010_sieve_param;

    localparam int unsigned LMAX     = 300;
    localparam int unsigned OVF_LMAX = 60;
    localparam int unsigned BUDGET   = 20000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] limit;
    logic        busy;
    logic        done;
    logic        error;
    logic [63:0] result;
    logic [31:0] count;

    logic        o_start;
    logic [31:0] o_limit;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [7:0]  o_result;
    logic [31:0] o_count;

`ifdef P0010_SIEVE_STREAM_EN
    logic        prime_valid;
    logic [31:0] prime_data;
    logic        prime_ready;
    logic        o_prime_valid;
    logic [31:0] o_prime_data;
    logic        o_prime_ready;
`endif

    int unsigned total;
    int unsigned bad;

    p0010_sieve_param #(.LIMIT_MAX(LMAX), .ADDR_W(32), .RESULT_W(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit),
`ifdef P0010_SIEVE_STREAM_EN
        .prime_valid(prime_valid), .prime_data(prime_data), .prime_ready(prime_ready),
`endif
        .busy(busy), .done(done), .error(error), .result(result), .count(count)
    );

    p0010_sieve_param #(.LIMIT_MAX(OVF_LMAX), .ADDR_W(32), .RESULT_W(8)) u_ovf (
        .clk(clk), .rst_n(rst_n), .start(o_start), .limit(o_limit),
`ifdef P0010_SIEVE_STREAM_EN
        .prime_valid(o_prime_valid), .prime_data(o_prime_data), .prime_ready(o_prime_ready),
`endif
        .busy(o_busy), .done(o_done), .error(o_error), .result(o_result), .count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_prime(input int unsigned k);
        if (k < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= k; d++) begin
            if (k % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void ref_model(input int unsigned n, output longint unsigned sum,
                                      output int unsigned cnt);
        sum = 0;
        cnt = 0;
        for (int unsigned k = 2; k <= n; k++) begin
            if (is_prime(k)) begin
                sum += k;
                cnt++;
            end
        end
    endfunction

    task automatic run_main(input logic [31:0] lim, output bit timeout);
        @(posedge clk); #1;
        start = 1'b1;
        limit = lim;
        @(posedge clk); #1;
        start = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_ovf(input logic [31:0] lim, output bit timeout);
        @(posedge clk); #1;
        o_start = 1'b1;
        o_limit = lim;
        @(posedge clk); #1;
        o_start = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (o_done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_run(input string name, input int unsigned lim, input bit timeout);
        longint unsigned es;
        int unsigned     ec;
        bit              ee;
        ee = (lim > LMAX);
        if (ee) begin
            es = 0;
            ec = 0;
        end else begin
            ref_model(lim, es, ec);
        end
        total++;
        if (timeout || done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done lim=%0d got=%b exp=1 timeout=%0d", name, lim, done, timeout);
        end
        total++;
        if (result !== es) begin
            bad++;
            $display("FAIL %s_result lim=%0d got=%0d exp=%0d", name, lim, result, es);
        end
        total++;
        if (count !== ec) begin
            bad++;
            $display("FAIL %s_count lim=%0d got=%0d exp=%0d", name, lim, count, ec);
        end
        total++;
        if (error !== ee || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_error lim=%0d got err=%b busy=%b exp err=%b busy=0", name, lim, error, busy, ee);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, error, o_busy, o_done, o_error} !== 6'b0 || result !== 64'd0 ||
            count !== 32'd0 || o_result !== 8'd0 || o_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b res=%0d cnt=%0d exp all 0",
                     busy, done, error, result, count);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        @(posedge clk); #1;
        start = 1'b1;
        limit = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        to = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check_run("basic", 10, to);
        total++;
        if (result !== 64'd17 || count !== 32'd4) begin
            bad++;
            $display("FAIL basic_const got res=%0d cnt=%0d exp res=17 cnt=4", result, count);
        end
    endtask

    task automatic test_small_bounds();
        bit to;
        for (int unsigned l = 0; l < 3; l++) begin
            run_main(l, to);
            check_run("small", l, to);
        end
        run_main(LMAX + 1, to);
        check_run("over", LMAX + 1, to);
        run_main(32'hFFFF_FFFF, to);
        total++;
        if (to || error !== 1'b1 || result !== 64'd0 || count !== 32'd0) begin
            bad++;
            $display("FAIL huge_limit got err=%b res=%0d cnt=%0d exp err=1 res=0 cnt=0", error, result, count);
        end
        run_main(LMAX, to);
        check_run("at_max", LMAX, to);
    endtask

    task automatic test_stale_sieve();
        bit to;
        run_main(10, to);
        check_run("stale_a", 10, to);
        run_main(30, to);
        check_run("stale_b", 30, to);
        total++;
        if (result !== 64'd129 || count !== 32'd10) begin
            bad++;
            $display("FAIL stale_const got res=%0d cnt=%0d exp res=129 cnt=10", result, count);
        end
    endtask

    task automatic test_busy_ignore();
        bit to;
        @(posedge clk); #1;
        start = 1'b1;
        limit = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        limit = 32'd30;
        @(posedge clk); #1;
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        check_run("busy_ignore", 10, to);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_idle got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
    endtask

    task automatic test_random();
        bit to;
        int unsigned l;
        for (int k = 0; k < 8; k++) begin
            l = $urandom_range(LMAX + 15, 0);
            run_main(l, to);
            check_run("random", l, to);
        end
    endtask

    task automatic test_mid_reset();
        bit to;
        @(posedge clk); #1;
        start = 1'b1;
        limit = LMAX;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LMAX + 10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, error} !== 3'b0 || result !== 64'd0 || count !== 32'd0) begin
            bad++;
            $display("FAIL midreset_outputs got busy=%b done=%b err=%b res=%0d cnt=%0d exp all 0",
                     busy, done, error, result, count);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_main(10, to);
        check_run("after_reset", 10, to);
    endtask

    task automatic test_overflow();
        bit to;
        longint unsigned es;
        int unsigned     ec;
        int unsigned     lims [3] = '{30, 50, 60};
        foreach (lims[i]) begin
            ref_model(lims[i], es, ec);
            run_ovf(lims[i], to);
            total++;
            if (to || o_done !== 1'b1 || o_result !== es[7:0] || o_count !== ec ||
                o_error !== (es > 255)) begin
                bad++;
                $display("FAIL overflow lim=%0d got done=%b res=%0d cnt=%0d err=%b exp res=%0d cnt=%0d err=%b",
                         lims[i], o_done, o_result, o_count, o_error, es[7:0], ec, (es > 255));
            end
        end
    endtask

`ifdef P0010_SIEVE_STREAM_EN
    task automatic test_stream();
        int unsigned got [$];
        int unsigned expq [$];
        bit          stalled;
        logic [31:0] held;
        bit          to;
        int          cyc;
        for (int unsigned k = 2; k <= 10; k++) if (is_prime(k)) expq.push_back(k);
        stalled = 1'b0;
        held = '0;
        cyc = 0;
        prime_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        limit = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            if (stalled) begin
                total++;
                if (prime_valid !== 1'b1 || prime_data !== held) begin
                    bad++;
                    $display("FAIL stream_stable got v=%b d=%0d exp v=1 d=%0d", prime_valid, prime_data, held);
                end
            end
            prime_ready = ((cyc / 3) % 2) == 1;
            cyc++;
            if (prime_valid === 1'b1 && prime_ready) begin
                got.push_back(prime_data);
                stalled = 1'b0;
            end else if (prime_valid === 1'b1) begin
                stalled = 1'b1;
                held = prime_data;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
        end
        prime_ready = 1'b1;
        total++;
        if (to || got.size() != expq.size()) begin
            bad++;
            $display("FAIL stream_len got=%0d exp=%0d timeout=%0d", got.size(), expq.size(), to);
        end else begin
            foreach (expq[i]) begin
                total++;
                if (got[i] != expq[i]) begin
                    bad++;
                    $display("FAIL stream_data idx=%0d got=%0d exp=%0d", i, got[i], expq[i]);
                end
            end
        end
        check_run("stream", 10, to);
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        start   = 1'b0;
        limit   = '0;
        o_start = 1'b0;
        o_limit = '0;
`ifdef P0010_SIEVE_STREAM_EN
        prime_ready   = 1'b1;
        o_prime_ready = 1'b1;
`endif
        test_reset();
        test_basic();
        test_small_bounds();
        test_stale_sieve();
        test_busy_ignore();
        test_random();
        test_mid_reset();
        test_overflow();
`ifdef P0010_SIEVE_STREAM_EN
        test_stream();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
